// File: rtl/lsu_pkg.sv
// Shared definitions for the LSU AXI master. This file holds the
// load/store op encodings, the controller state enum and the AXI OKAY
// response code.
package lsu_pkg;

   // Core-side access size and extension.
   // Stores use only OP_B, OP_H and OP_W.
   typedef enum logic [2:0] {
      OP_B  = 3'd0,
      OP_H  = 3'd1,
      OP_W  = 3'd2,
      OP_BU = 3'd4,
      OP_HU = 3'd5
   } lsu_op_e;

   // Controller states. Only one bus transaction is in flight at a time.
   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_ADDR,
      S_RD_DATA,
      S_WR_REQ,
      S_WR_RESP
   } lsu_state_e;

   localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic for the LSU.
// The store path shifts the store data into its lane and builds the
// byte strobe. The load path picks the addressed byte or halfword out
// of the bus word and sign- or zero-extends it.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  st_op_i,
   input  logic [1:0]  st_addr_lo_i,
   input  logic [31:0] st_wdata_i,
   output logic [31:0] st_wdata_o,
   output logic [3:0]  st_wstrb_o,
   input  logic [2:0]  ld_op_i,
   input  logic [1:0]  ld_addr_lo_i,
   input  logic [31:0] ld_rdata_i,
   output logic [31:0] ld_data_o
);

   logic [15:0] ld_lane;

   // Store lane: shift the data up by the byte offset and strobe the touched bytes.
   always_comb begin
      // NOTE: every output gets a default before the case so no path can infer a latch.
      st_wdata_o = st_wdata_i << {st_addr_lo_i, 3'b000};
      st_wstrb_o = 4'hF;
      case (lsu_op_e'(st_op_i))
         OP_B:    st_wstrb_o = 4'b0001 << st_addr_lo_i;
         OP_H:    st_wstrb_o = 4'b0011 << st_addr_lo_i;
         default: st_wstrb_o = 4'hF;
      endcase
   end

   // Load lane: bring the addressed byte or half down to bit 0, then extend it per op.
   always_comb begin
      ld_lane   = 16'(ld_rdata_i >> {ld_addr_lo_i, 3'b000});
      ld_data_o = ld_rdata_i;
      case (lsu_op_e'(ld_op_i))
         OP_B:    ld_data_o = {{24{ld_lane[7]}}, ld_lane[7:0]};
         OP_BU:   ld_data_o = {24'h000000, ld_lane[7:0]};
         OP_H:    ld_data_o = {{16{ld_lane[15]}}, ld_lane};
         OP_HU:   ld_data_o = {16'h0000, ld_lane};
         default: ld_data_o = ld_rdata_i;
      endcase
   end

endmodule

// File: rtl/lsu_axi_master.sv
// Single-outstanding AXI-lite style master for core loads and stores.
// A load runs IDLE -> RD_ADDR -> RD_DATA -> IDLE.
// A store runs IDLE -> WR_REQ -> WR_RESP -> IDLE.
// All bus-facing outputs are registered.
// Optional build macro: LSU_TIMEOUT_EN. When it is defined, a wait in
// RD_DATA or WR_RESP ends after TIMEOUT_CYC cycles with an error
// response. Without the macro, the wait is unbounded.
module lsu_axi_master
   import lsu_pkg::*;
#(
   parameter int TIMEOUT_CYC = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wen,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_awvalid,
   input  logic        mem_awready,
   output logic [31:0] mem_awaddr,
   output logic        mem_wvalid,
   input  logic        mem_wready,
   output logic [31:0] mem_wdata,
   output logic [7:0]  mem_wstrb,
   input  logic        mem_bvalid,
   output logic        mem_bready,
   input  logic [1:0]  mem_bresp,
   output logic        mem_arvalid,
   input  logic        mem_arready,
   output logic [31:0] mem_araddr,
   input  logic        mem_rvalid,
   output logic        mem_rready,
   input  logic [1:0]  mem_rresp,
   input  logic [31:0] mem_rdata
);

   lsu_state_e  state_q;
   logic [31:0] addr_q;
   logic [2:0]  op_q;
   logic [31:0] wdata_q;
   logic [3:0]  wstrb_q;
   logic        req_ready_q;
   logic        awvalid_q;
   logic        wvalid_q;
   logic        bready_q;
   logic        arvalid_q;
   logic        rready_q;
   logic        resp_valid_q;
   logic        resp_err_q;
   logic [31:0] resp_rdata_q;

   logic [31:0] st_wdata_al;
   logic [3:0]  st_wstrb_al;
   logic [31:0] ld_data_ext;
   logic        tmo_hit;

   lsu_align u_align (
      .st_op_i      (req_op),
      .st_addr_lo_i (req_addr[1:0]),
      .st_wdata_i   (req_wdata),
      .st_wdata_o   (st_wdata_al),
      .st_wstrb_o   (st_wstrb_al),
      .ld_op_i      (op_q),
      .ld_addr_lo_i (addr_q[1:0]),
      .ld_rdata_i   (mem_rdata),
      .ld_data_o    (ld_data_ext)
   );

`ifdef LSU_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   logic [TW-1:0] tmo_q, tmo_d;

   // Response-wait counter: it counts the cycles already spent waiting and is cleared everywhere else.
   always_comb begin
      tmo_d   = '0;
      tmo_hit = (tmo_q == TW'(TIMEOUT_CYC - 1));
      if (state_q == S_RD_DATA || state_q == S_WR_RESP) tmo_d = tmo_q + 1'b1;
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (!rst) tmo_q <= '0;
      else      tmo_q <= tmo_d;
   end
`else
   // TIMEOUT_CYC only matters in the timeout build.
   logic unused_timeout_cyc;
   assign unused_timeout_cyc = ^TIMEOUT_CYC;
   assign tmo_hit            = 1'b0;
`endif

   // Controller FSM. Every bus-facing output is a register set here.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so later reads in this block see the old value.
      if (!rst) begin
         // NOTE: the data/address registers are reset too, because they drive output ports that must read 0 in reset.
         state_q      <= S_IDLE;
         addr_q       <= '0;
         op_q         <= '0;
         wdata_q      <= '0;
         wstrb_q      <= '0;
         req_ready_q  <= 1'b0;
         awvalid_q    <= 1'b0;
         wvalid_q     <= 1'b0;
         bready_q     <= 1'b0;
         arvalid_q    <= 1'b0;
         rready_q     <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
      end else begin
         resp_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               req_ready_q <= 1'b1;
               if (req_valid && req_ready_q) begin
                  req_ready_q <= 1'b0;
                  addr_q      <= req_addr;
                  op_q        <= req_op;
                  if (req_wen) begin
                     wdata_q   <= st_wdata_al;
                     wstrb_q   <= st_wstrb_al;
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                     state_q   <= S_WR_REQ;
                  end else begin
                     arvalid_q <= 1'b1;
                     state_q   <= S_RD_ADDR;
                  end
               end
            end
            S_RD_ADDR: begin
               if (mem_arready) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  state_q   <= S_RD_DATA;
               end
            end
            S_RD_DATA: begin
               if (mem_rvalid) begin
                  rready_q     <= 1'b0;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= (mem_rresp != RESP_OKAY);
                  resp_rdata_q <= ld_data_ext;
                  req_ready_q  <= 1'b1;
                  state_q      <= S_IDLE;
               end else if (tmo_hit) begin
                  rready_q     <= 1'b0;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= 1'b1;
                  resp_rdata_q <= '0;
                  req_ready_q  <= 1'b1;
                  state_q      <= S_IDLE;
               end
            end
            S_WR_REQ: begin
               // The address and data channels retire independently. Move on once neither is still pending.
               if (mem_awready) awvalid_q <= 1'b0;
               if (mem_wready)  wvalid_q  <= 1'b0;
               if ((!awvalid_q || mem_awready) && (!wvalid_q || mem_wready)) begin
                  bready_q <= 1'b1;
                  state_q  <= S_WR_RESP;
               end
            end
            S_WR_RESP: begin
               if (mem_bvalid) begin
                  bready_q     <= 1'b0;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= (mem_bresp != RESP_OKAY);
                  resp_rdata_q <= '0;
                  req_ready_q  <= 1'b1;
                  state_q      <= S_IDLE;
               end else if (tmo_hit) begin
                  bready_q     <= 1'b0;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= 1'b1;
                  resp_rdata_q <= '0;
                  req_ready_q  <= 1'b1;
                  state_q      <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign req_ready   = req_ready_q;
   assign resp_valid  = resp_valid_q;
   assign resp_rdata  = resp_rdata_q;
   assign resp_err    = resp_err_q;
   assign mem_awvalid = awvalid_q;
   assign mem_awaddr  = addr_q;
   assign mem_wvalid  = wvalid_q;
   assign mem_wdata   = wdata_q;
   assign mem_wstrb   = {4'b0000, wstrb_q};
   assign mem_bready  = bready_q;
   assign mem_arvalid = arvalid_q;
   assign mem_araddr  = addr_q;
   assign mem_rready  = rready_q;

endmodule

// File: tb/tb_lsu_axi_master.sv
// Directed bench for lsu_axi_master. The bench acts as the memory side
// cycle by cycle. Inputs change on the falling edge and outputs are
// sampled there. The timeout scenario runs only when LSU_TIMEOUT_EN
// is defined.
module tb_lsu_axi_master;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_wen;
   logic [2:0]  req_op;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic        mem_awvalid, mem_awready;
   logic [31:0] mem_awaddr;
   logic        mem_wvalid, mem_wready;
   logic [31:0] mem_wdata;
   logic [7:0]  mem_wstrb;
   logic        mem_bvalid, mem_bready;
   logic [1:0]  mem_bresp;
   logic        mem_arvalid, mem_arready;
   logic [31:0] mem_araddr;
   logic        mem_rvalid, mem_rready;
   logic [1:0]  mem_rresp;
   logic [31:0] mem_rdata;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   lsu_axi_master #(.TIMEOUT_CYC(8)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
      .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_awvalid(mem_awvalid), .mem_awready(mem_awready), .mem_awaddr(mem_awaddr),
      .mem_wvalid(mem_wvalid), .mem_wready(mem_wready), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb),
      .mem_bvalid(mem_bvalid), .mem_bready(mem_bready), .mem_bresp(mem_bresp),
      .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_araddr(mem_araddr),
      .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_rresp(mem_rresp),
      .mem_rdata(mem_rdata)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Present one request for one clock, starting from an idle DUT.
   task automatic issue(input logic wen, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata);
      check("req_ready_idle", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_wen = wen; req_op = op; req_addr = addr; req_wdata = wdata;
      @(negedge clk);
      req_valid = 1'b0;
      check("req_ready_busy", 32'(req_ready), 32'd0);
   endtask

   task automatic do_load(input string tag, input logic [2:0] op, input logic [31:0] addr,
                          input int ar_delay, input logic [31:0] rdata, input logic [1:0] rresp,
                          input logic [31:0] exp_data, input logic exp_err);
      issue(1'b0, op, addr, 32'h0);
      for (int c = 0; c < ar_delay; c++) begin
         check({tag, "_arvalid_hold"}, 32'(mem_arvalid), 32'd1);
         check({tag, "_araddr_hold"}, mem_araddr, addr);
         @(negedge clk);
      end
      check({tag, "_arvalid"}, 32'(mem_arvalid), 32'd1);
      check({tag, "_araddr"}, mem_araddr, addr);
      mem_arready = 1'b1;
      @(negedge clk);
      mem_arready = 1'b0;
      check({tag, "_arvalid_drop"}, 32'(mem_arvalid), 32'd0);
      check({tag, "_rready"}, 32'(mem_rready), 32'd1);
      check({tag, "_no_early_resp"}, 32'(resp_valid), 32'd0);
      mem_rvalid = 1'b1; mem_rdata = rdata; mem_rresp = rresp;
      @(negedge clk);
      mem_rvalid = 1'b0; mem_rdata = 32'h0; mem_rresp = 2'b00;
      check({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
      check({tag, "_rdata"}, resp_rdata, exp_data);
      check({tag, "_err"}, 32'(resp_err), 32'(exp_err));
      check({tag, "_rready_drop"}, 32'(mem_rready), 32'd0);
      @(negedge clk);
      check({tag, "_resp_pulse"}, 32'(resp_valid), 32'd0);
   endtask

   // Drive the write request up to the first WR_RESP cycle. awready is
   // raised aw_at cycles into WR_REQ and wready is raised w_at cycles in.
   task automatic store_req(input string tag, input logic [2:0] op, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] exp_wdata,
                            input logic [7:0] exp_wstrb, input int aw_at, input int w_at);
      int last;
      last = (aw_at > w_at) ? aw_at : w_at;
      issue(1'b1, op, addr, wdata);
      for (int c = 0; c <= last; c++) begin
         check({tag, "_awvalid"}, 32'(mem_awvalid), (c <= aw_at) ? 32'd1 : 32'd0);
         check({tag, "_wvalid"}, 32'(mem_wvalid), (c <= w_at) ? 32'd1 : 32'd0);
         check({tag, "_awaddr"}, mem_awaddr, addr);
         check({tag, "_wdata"}, mem_wdata, exp_wdata);
         check({tag, "_wstrb"}, 32'(mem_wstrb), 32'(exp_wstrb));
         check({tag, "_no_early_resp"}, 32'(resp_valid), 32'd0);
         mem_awready = (c == aw_at);
         mem_wready  = (c == w_at);
         @(negedge clk);
      end
      mem_awready = 1'b0;
      mem_wready  = 1'b0;
      check({tag, "_awvalid_done"}, 32'(mem_awvalid), 32'd0);
      check({tag, "_wvalid_done"}, 32'(mem_wvalid), 32'd0);
      check({tag, "_bready"}, 32'(mem_bready), 32'd1);
   endtask

   task automatic store_bresp(input string tag, input logic [1:0] bresp, input logic exp_err);
      mem_bvalid = 1'b1; mem_bresp = bresp;
      @(negedge clk);
      mem_bvalid = 1'b0; mem_bresp = 2'b00;
      check({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
      check({tag, "_err"}, 32'(resp_err), 32'(exp_err));
      check({tag, "_bready_drop"}, 32'(mem_bready), 32'd0);
      @(negedge clk);
      check({tag, "_single_resp_a"}, 32'(resp_valid), 32'd0);
      @(negedge clk);
      check({tag, "_single_resp_b"}, 32'(resp_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within the time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      req_valid = 1'b0; req_wen = 1'b0; req_op = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
      mem_awready = 1'b0; mem_wready = 1'b0; mem_bvalid = 1'b0; mem_bresp = 2'b00;
      mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rresp = 2'b00; mem_rdata = 32'h0;
      repeat (2) @(negedge clk);

      // Reset state
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_arvalid", 32'(mem_arvalid), 32'd0);
      check("rst_awvalid", 32'(mem_awvalid), 32'd0);
      check("rst_wvalid", 32'(mem_wvalid), 32'd0);
      check("rst_bready", 32'(mem_bready), 32'd0);
      check("rst_rready", 32'(mem_rready), 32'd0);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_err", 32'(resp_err), 32'd0);
      check("rst_wstrb", 32'(mem_wstrb), 32'd0);
      check("rst_awaddr", mem_awaddr, 32'h0);
      check("rst_wdata", mem_wdata, 32'h0);
      rst = 1'b1;
      @(negedge clk);
      check("post_rst_req_ready", 32'(req_ready), 32'd1);

      // Loads
      do_load("lw",     3'd2, 32'h8000_0004, 3, 32'hDEAD_BEEF, 2'b00, 32'hDEAD_BEEF, 1'b0);
      do_load("lb",     3'd0, 32'h8000_0003, 0, 32'h80FF_FFFF, 2'b00, 32'hFFFF_FF80, 1'b0);
      do_load("lbu",    3'd4, 32'h8000_0003, 0, 32'h80FF_FFFF, 2'b00, 32'h0000_0080, 1'b0);
      do_load("lhu",    3'd5, 32'h8000_0002, 1, 32'h1234_ABCD, 2'b00, 32'h0000_1234, 1'b0);
      do_load("lh",     3'd1, 32'h8000_0000, 0, 32'h0000_ABCD, 2'b00, 32'hFFFF_ABCD, 1'b0);
      do_load("lw_err", 3'd2, 32'h8000_0010, 0, 32'hCAFE_F00D, 2'b10, 32'hCAFE_F00D, 1'b1);

      // Stores: wready two cycles after awready, same-cycle handshakes, and wready before awready.
      store_req("sh", 3'd1, 32'h8000_0002, 32'h0000_BEEF, 32'hBEEF_0000, 8'h0C, 0, 2);
      store_bresp("sh", 2'b00, 1'b0);
      store_req("sb", 3'd0, 32'h8000_0001, 32'h0000_00A5, 32'h0000_A500, 8'h02, 0, 0);
      store_bresp("sb", 2'b00, 1'b0);
      store_req("sw", 3'd2, 32'h8000_0008, 32'h1234_5678, 32'h1234_5678, 8'h0F, 2, 0);
      store_bresp("sw", 2'b11, 1'b1);

      // Reset asserted during RD_DATA aborts the load without a response.
      issue(1'b0, 3'd2, 32'h8000_0020, 32'h0);
      mem_arready = 1'b1;
      @(negedge clk);
      mem_arready = 1'b0;
      check("abort_rready_before", 32'(mem_rready), 32'd1);
      rst = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
      @(negedge clk);
      check("abort_rready", 32'(mem_rready), 32'd0);
      check("abort_resp_valid", 32'(resp_valid), 32'd0);
      check("abort_req_ready", 32'(req_ready), 32'd0);
      check("abort_araddr", mem_araddr, 32'h0);
      rst = 1'b1;
      mem_rvalid = 1'b0; mem_rdata = 32'h0;
      @(negedge clk);
      check("abort_no_resp", 32'(resp_valid), 32'd0);
      check("abort_idle_ready", 32'(req_ready), 32'd1);
      do_load("lw_after_abort", 3'd2, 32'h8000_0024, 0, 32'h0BAD_F00D, 2'b00, 32'h0BAD_F00D, 1'b0);

`ifdef LSU_TIMEOUT_EN
      // Store whose bvalid never arrives: the response comes 8 cycles after WR_RESP is entered.
      store_req("tmo", 3'd2, 32'h8000_0030, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 8'h0F, 0, 0);
      for (int i = 0; i < 8; i++) begin
         check("tmo_wait_no_resp", 32'(resp_valid), 32'd0);
         @(negedge clk);
      end
      check("tmo_resp_valid", 32'(resp_valid), 32'd1);
      check("tmo_resp_err", 32'(resp_err), 32'd1);
      check("tmo_resp_rdata", resp_rdata, 32'h0);
      check("tmo_bready_drop", 32'(mem_bready), 32'd0);
      check("tmo_req_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      check("tmo_resp_pulse", 32'(resp_valid), 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/lsu_axi_master.md
LSU_AXI_MASTER -- requirements
Module: lsu_axi_master
Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255, max cycles waiting for bvalid/rvalid (used only with LSU_TIMEOUT_EN).
REQ-002 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  core load/store request.
REQ-005 SHALL have port req_ready  output  1  request accepted when req_valid && req_ready.
REQ-006 SHALL have port req_wen  input  1  1=store, 0=load.
REQ-007 SHALL have port req_op  input  3  0=b, 1=h, 2=w, 4=bu, 5=hu (stores use 0/1/2 only).
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data, LSB-aligned.
REQ-010 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata  output  32  extended load data, valid with resp_valid.
REQ-012 SHALL have port resp_err  output  1  nonzero bresp/rresp or timeout, valid with resp_valid.
REQ-013 SHALL have ports mem_awvalid out 1, mem_awready in 1, mem_awaddr out 32, for the write-address channel.
REQ-014 SHALL have ports mem_wvalid out 1, mem_wready in 1, mem_wdata out 32, mem_wstrb out 8, for the write-data channel; mem_wstrb[7:4] are always 0.
REQ-015 SHALL have ports mem_bvalid in 1, mem_bready out 1, mem_bresp in 2, for the write-response channel.
REQ-016 SHALL have ports mem_arvalid out 1, mem_arready in 1, mem_araddr out 32, for the read-address channel.
REQ-017 SHALL have ports mem_rvalid in 1, mem_rready out 1, mem_rresp in 2, mem_rdata in 32, for the read-data channel.
Function
REQ-018 SHALL implement FSM IDLE -> RD_ADDR -> RD_DATA -> IDLE and IDLE -> WR_REQ -> WR_RESP -> IDLE; only one transaction is outstanding.
REQ-019 SHALL assert req_ready only in IDLE; on accept, it SHALL register addr, op, wen, and the aligned wdata/wstrb.
REQ-020 SHALL hold mem_arvalid=1 with stable mem_araddr=req_addr in RD_ADDR until the arready handshake, then move to RD_DATA with mem_rready=1.
REQ-021 SHALL, in WR_REQ, raise awvalid and wvalid in the same cycle, drop each independently on its own handshake, and enter WR_RESP after both complete; the two handshakes may complete in either order or in the same cycle.
REQ-022 SHALL hold mem_bready=1 in WR_RESP and pulse resp_valid in the cycle after the bvalid handshake.
REQ-023 SHALL never make valid signals depend on ready signals, and SHALL keep address/data stable while valid is high.
REQ-024 SHALL shift store data into the lane: mem_wdata = req_wdata << (8*addr[1:0]).
REQ-025 SHALL set mem_wstrb for sb to 1<<addr[1:0], for sh to 3<<addr[1:0] (addr[1:0] in {0,1,2}), and for sw to 4'hF.
REQ-026 SHALL select the load byte/half from mem_rdata by the registered addr[1:0], then sign- or zero-extend per op.
REQ-027 SHALL make resp_valid one cycle after the rvalid/bvalid handshake and return to IDLE in that same cycle, so back-to-back requests have a minimum 1-cycle bubble.
REQ-028 SHALL produce resp_err=1 iff the captured resp != 0; the data is still returned.
Reset
REQ-029 SHALL, while rst=0 at posedge, go to IDLE with all valid/ready outputs, resp_valid, resp_err and counters 0, mem_wstrb=0 and data/address outputs 0, and SHALL abort any in-flight transaction without a response.
Configuration
REQ-030 SHALL, with LSU_TIMEOUT_EN defined, count cycles in RD_DATA/WR_RESP and on reaching TIMEOUT_CYC pulse resp_valid with resp_err=1 and resp_rdata=0 and return to IDLE; without the macro, there SHALL be no counter and the wait is unbounded.
Structure
REQ-031 SHALL keep op encodings, the FSM state enum and the OKAY response constant (2'b00) in shared package lsu_pkg.
REQ-032 SHALL put the lane logic (wstrb/wdata shift, load extract/extend) in sub-module lsu_align.
Verification
REQ-033 SHALL check: lw addr 0x80000004, rdata 0xDEADBEEF after 3-cycle arready delay -> resp_rdata=0xDEADBEEF, resp_err=0.
REQ-034 SHALL check: lb addr 0x80000003, rdata 0x80FFFFFF -> 0xFFFFFF80; lbu same -> 0x00000080; lhu addr ...2, rdata 0x1234ABCD -> 0x00001234.
REQ-035 SHALL check: sh addr 0x80000002, wdata 0x0000BEEF -> mem_wdata=0xBEEF0000, mem_wstrb=8'h0C; with wready 2 cycles after awready, exactly one resp_valid.
REQ-036 SHALL check: read with rresp=2'b10 -> resp_err=1; rst driven low in RD_DATA -> IDLE next cycle, no resp_valid.
REQ-037 SHALL check, with LSU_TIMEOUT_EN and TIMEOUT_CYC=8: store with bvalid never asserted -> resp_valid and resp_err=1 exactly 8 cycles after entering WR_RESP.
